// File: rtl/vram_arbiter_if.sv
// Requester, read-return and RAM-command signals of the VRAM arbiter.
// The arbiter takes the slave view; the requesters plus RAM take the master view.
interface vram_arbiter_if #(
  parameter int unsigned AW = 13,
  parameter int unsigned DW = 8
);
  logic          i_vid_req;
  logic [AW-1:0] i_vid_addr;
  logic          o_vid_ack;
  logic          o_vid_rvalid;

  logic          i_cpu_req;
  logic          i_cpu_we;
  logic [AW-1:0] i_cpu_addr;
  logic [DW-1:0] i_cpu_wdata;
  logic          o_cpu_ack;
  logic          o_cpu_rvalid;

  logic          i_dma_req;
  logic          i_dma_we;
  logic [AW-1:0] i_dma_addr;
  logic [DW-1:0] i_dma_wdata;
  logic          o_dma_ack;
  logic          o_dma_rvalid;

  logic [DW-1:0] o_rdata;

  logic          o_ram_en;
  logic          o_ram_we;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_wdata;
  logic [DW-1:0] i_ram_rdata;

  modport slave (
    input  i_vid_req, i_vid_addr,
    input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    input  i_dma_req, i_dma_we, i_dma_addr, i_dma_wdata,
    input  i_ram_rdata,
    output o_vid_ack, o_vid_rvalid,
    output o_cpu_ack, o_cpu_rvalid,
    output o_dma_ack, o_dma_rvalid,
    output o_rdata,
    output o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata
  );

  modport master (
    output i_vid_req, i_vid_addr,
    output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    output i_dma_req, i_dma_we, i_dma_addr, i_dma_wdata,
    output i_ram_rdata,
    input  o_vid_ack, o_vid_rvalid,
    input  o_cpu_ack, o_cpu_rvalid,
    input  o_dma_ack, o_dma_rvalid,
    input  o_rdata,
    input  o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video has fixed priority, CPU/DMA share round-robin,
// and a CPU/DMA request that has waited STARVE cycles overrides video.
module vram_arbiter #(
  parameter int unsigned AW     = 13,
  parameter int unsigned DW     = 8,
  parameter int unsigned STARVE = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  vram_arbiter_if.slave   bus
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] STARVE_C = CW'(STARVE);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_VID  = 2'd1,
    SRC_CPU  = 2'd2,
    SRC_DMA  = 2'd3
  } src_e;

  logic [CW-1:0] cnt_cpu;
  logic [CW-1:0] cnt_dma;
  logic          rr_dma_last;
  logic          cpu_starved;
  logic          dma_starved;
  src_e          win;
  src_e          tie;
  src_e          tag_q;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign cpu_starved = bus.i_cpu_req && (cnt_cpu == STARVE_C);
  assign dma_starved = bus.i_dma_req && (cnt_dma == STARVE_C);

  // Winner selection: starvation, then video, then round-robin between CPU and DMA.
  always_comb begin
    win = SRC_NONE;
    tie = rr_dma_last ? SRC_CPU : SRC_DMA;
    if (i_rst) begin
      win = SRC_NONE;
    end else if (cpu_starved && dma_starved) begin
      win = tie;
    end else if (cpu_starved) begin
      win = SRC_CPU;
    end else if (dma_starved) begin
      win = SRC_DMA;
    end else if (bus.i_vid_req) begin
      win = SRC_VID;
    end else if (bus.i_cpu_req && bus.i_dma_req) begin
      win = tie;
    end else if (bus.i_cpu_req) begin
      win = SRC_CPU;
    end else if (bus.i_dma_req) begin
      win = SRC_DMA;
    end
  end

  assign bus.o_vid_ack = (win == SRC_VID);
  assign bus.o_cpu_ack = (win == SRC_CPU);
  assign bus.o_dma_ack = (win == SRC_DMA);
  assign bus.o_rdata   = bus.i_ram_rdata;

  // Command fields of the winning requester; video is always a read.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (win)
      SRC_VID: begin
        sel_addr  = bus.i_vid_addr;
      end
      SRC_CPU: begin
        sel_we    = bus.i_cpu_we;
        sel_addr  = bus.i_cpu_addr;
        sel_wdata = bus.i_cpu_wdata;
      end
      SRC_DMA: begin
        sel_we    = bus.i_dma_we;
        sel_addr  = bus.i_dma_addr;
        sel_wdata = bus.i_dma_wdata;
      end
      default: ;
    endcase
  end

  // Wait counters and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_cpu     <= '0;
      cnt_dma     <= '0;
      rr_dma_last <= 1'b1;
    end else begin
      if (!bus.i_cpu_req || win == SRC_CPU) begin
        cnt_cpu <= '0;
      end else if (cnt_cpu < STARVE_C) begin
        cnt_cpu <= cnt_cpu + CW'(1);
      end
      if (!bus.i_dma_req || win == SRC_DMA) begin
        cnt_dma <= '0;
      end else if (cnt_dma < STARVE_C) begin
        cnt_dma <= cnt_dma + CW'(1);
      end
      if (win == SRC_CPU) begin
        rr_dma_last <= 1'b0;
      end else if (win == SRC_DMA) begin
        rr_dma_last <= 1'b1;
      end
    end
  end

  // RAM command registers; address and wdata hold when idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_ram_en    <= 1'b0;
      bus.o_ram_we    <= 1'b0;
      bus.o_ram_addr  <= '0;
      bus.o_ram_wdata <= '0;
    end else if (win != SRC_NONE) begin
      bus.o_ram_en    <= 1'b1;
      bus.o_ram_we    <= sel_we;
      bus.o_ram_addr  <= sel_addr;
      bus.o_ram_wdata <= sel_wdata;
    end else begin
      bus.o_ram_en    <= 1'b0;
      bus.o_ram_we    <= 1'b0;
    end
  end

  // Read-return tag pipeline, two stages to match the RAM's one-cycle latency.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tag_q            <= SRC_NONE;
      bus.o_vid_rvalid <= 1'b0;
      bus.o_cpu_rvalid <= 1'b0;
      bus.o_dma_rvalid <= 1'b0;
    end else begin
      tag_q            <= (win != SRC_NONE && !sel_we) ? win : SRC_NONE;
      bus.o_vid_rvalid <= (tag_q == SRC_VID);
      bus.o_cpu_rvalid <= (tag_q == SRC_CPU);
      bus.o_dma_rvalid <= (tag_q == SRC_DMA);
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: cycle-level reference model plus directed scenarios
// with literal expectations for reset, latency, round-robin and starvation.
module tb_vram_arbiter;

  localparam int unsigned AW     = 13;
  localparam int unsigned DW     = 8;
  localparam int unsigned STARVE = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_arbiter_if #(.AW(AW), .DW(DW)) bus();

  vram_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Synchronous RAM with one-cycle read latency.
  logic [DW-1:0] ram_mem   [1<<AW];
  logic [DW-1:0] model_mem [1<<AW];
  always @(posedge clk) begin
    if (bus.o_ram_en) begin
      if (bus.o_ram_we) ram_mem[bus.o_ram_addr] <= bus.o_ram_wdata;
      else              bus.i_ram_rdata <= ram_mem[bus.o_ram_addr];
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit run    = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state: port codes 0=none 1=vid 2=cpu 3=dma.
  typedef struct {
    int due;
    int port;
    int data;
  } rd_t;

  int  m_cnt_cpu  = 0;
  int  m_cnt_dma  = 0;
  bit  m_last_dma = 1'b1;
  int  m_last_acc = -10;
  bit  m_last_we  = 1'b0;
  int  m_addr     = 0;
  int  m_wdata    = 0;
  rd_t pend[$];

  function automatic int pick(input bit r, input bit vr, input bit cr, input bit dr,
                              input int cc, input int dc, input bit last_dma);
    bit cs, ds;
    int tie_port;
    cs = cr && (cc >= int'(STARVE));
    ds = dr && (dc >= int'(STARVE));
    tie_port = last_dma ? 2 : 3;
    if (r)        return 0;
    if (cs && ds) return tie_port;
    if (cs)       return 2;
    if (ds)       return 3;
    if (vr)       return 1;
    if (cr && dr) return tie_port;
    if (cr)       return 2;
    if (dr)       return 3;
    return 0;
  endfunction

  function automatic int port_bit(input int p);
    return (p == 1) ? 4 : (p == 2) ? 2 : (p == 3) ? 1 : 0;
  endfunction

  // Per-cycle comparison against the model, then advance the model across the edge.
  always @(negedge clk) begin : compare
    int w, exp_rv, exp_data, a, d;
    bit vr, cr, dr, we;
    if (run) begin
      vr = bus.i_vid_req; cr = bus.i_cpu_req; dr = bus.i_dma_req;
      w = pick(rst, vr, cr, dr, m_cnt_cpu, m_cnt_dma, m_last_dma);
      chk("acks", int'({bus.o_vid_ack, bus.o_cpu_ack, bus.o_dma_ack}), port_bit(w));
      chk("ram_en", int'(bus.o_ram_en), int'(m_last_acc == cyc - 1));
      chk("ram_we", int'(bus.o_ram_we), int'((m_last_acc == cyc - 1) && m_last_we));
      chk("ram_addr", int'(bus.o_ram_addr), m_addr);
      chk("ram_wdata", int'(bus.o_ram_wdata), m_wdata);
      exp_rv = 0; exp_data = 0;
      foreach (pend[i]) if (pend[i].due == cyc) begin
        exp_rv = port_bit(pend[i].port);
        exp_data = pend[i].data;
      end
      chk("rvalid", int'({bus.o_vid_rvalid, bus.o_cpu_rvalid, bus.o_dma_rvalid}), exp_rv);
      if (exp_rv != 0) chk("rdata", int'(bus.o_rdata), exp_data);
      for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].due <= cyc) pend.delete(i);

      if (rst) begin
        m_cnt_cpu = 0; m_cnt_dma = 0; m_last_dma = 1'b1;
        m_last_acc = -10; m_last_we = 1'b0; m_addr = 0; m_wdata = 0;
        pend.delete();
      end else begin
        m_cnt_cpu = (!cr || w == 2) ? 0 : ((m_cnt_cpu + 1 > int'(STARVE)) ? int'(STARVE) : m_cnt_cpu + 1);
        m_cnt_dma = (!dr || w == 3) ? 0 : ((m_cnt_dma + 1 > int'(STARVE)) ? int'(STARVE) : m_cnt_dma + 1);
        if (w == 2) m_last_dma = 1'b0;
        if (w == 3) m_last_dma = 1'b1;
        if (w != 0) begin
          we = 1'b0; a = int'(bus.i_vid_addr); d = 0;
          if (w == 2) begin we = bus.i_cpu_we; a = int'(bus.i_cpu_addr); d = int'(bus.i_cpu_wdata); end
          if (w == 3) begin we = bus.i_dma_we; a = int'(bus.i_dma_addr); d = int'(bus.i_dma_wdata); end
          m_last_acc = cyc; m_last_we = we; m_addr = a; m_wdata = d;
          if (we) model_mem[a] = DW'(d);
          else    pend.push_back('{cyc + 2, w, int'(model_mem[a])});
        end
      end
      cyc++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic clear_reqs();
    bus.i_vid_req = 1'b0; bus.i_cpu_req = 1'b0; bus.i_dma_req = 1'b0;
    bus.i_cpu_we  = 1'b0; bus.i_dma_we  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i]   = DW'(i * 7);
      model_mem[i] = DW'(i * 7);
    end
    ram_mem[13'h0400]   = 8'h5A;
    model_mem[13'h0400] = 8'h5A;
    bus.i_ram_rdata = '0;
    bus.i_vid_addr = '0; bus.i_cpu_addr = '0; bus.i_dma_addr = '0;
    bus.i_cpu_wdata = '0; bus.i_dma_wdata = '0;
    clear_reqs();
    rst = 1'b1;
    next_cycle();
    run = 1'b1;

    // Reset held with every requester active.
    bus.i_vid_req = 1'b1; bus.i_vid_addr = 13'h0010;
    bus.i_cpu_req = 1'b1; bus.i_cpu_addr = 13'h0020;
    bus.i_dma_req = 1'b1; bus.i_dma_addr = 13'h0030;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_acks", int'({bus.o_vid_ack, bus.o_cpu_ack, bus.o_dma_ack}), 0);
      chk("rst_ram_en", int'(bus.o_ram_en), 0);
      chk("rst_rvalid", int'({bus.o_vid_rvalid, bus.o_cpu_rvalid, bus.o_dma_rvalid}), 0);
      next_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rst_first_vid", int'({bus.o_vid_ack, bus.o_cpu_ack, bus.o_dma_ack}), 4);
    next_cycle();
    clear_reqs();
    idle(3);

    // CPU reads and DMA writes contend without video.
    bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 13'h0100;
    bus.i_dma_req = 1'b1; bus.i_dma_we = 1'b1; bus.i_dma_addr = 13'h0200; bus.i_dma_wdata = 8'h11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_ack", int'({bus.o_cpu_ack, bus.o_dma_ack}), (k % 2 == 0) ? 2 : 1);
      if (k > 0) chk("rr_ram_en", int'(bus.o_ram_en), 1);
      next_cycle();
    end
    clear_reqs();
    idle(3);

    // Double starvation under continuous video.
    bus.i_vid_req = 1'b1; bus.i_vid_addr = 13'h0040;
    bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b1; bus.i_cpu_addr = 13'h0800; bus.i_cpu_wdata = 8'h33;
    bus.i_dma_req = 1'b1; bus.i_dma_we = 1'b0; bus.i_dma_addr = 13'h0900;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      chk("dstarve_ack", int'({bus.o_vid_ack, bus.o_cpu_ack, bus.o_dma_ack}),
          (k == 8) ? 2 : (k == 9) ? 1 : 4);
      next_cycle();
      if (k == 8) bus.i_cpu_req = 1'b0;
      if (k == 9) bus.i_dma_req = 1'b0;
    end
    clear_reqs();
    idle(3);

    // Single CPU write starved by video.
    bus.i_vid_req = 1'b1; bus.i_vid_addr = 13'h0041;
    bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b1; bus.i_cpu_addr = 13'h1000; bus.i_cpu_wdata = 8'hA5;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("starve_ack", int'({bus.o_vid_ack, bus.o_cpu_ack}), (k == 8) ? 1 : 2);
      if (k == 9) begin
        chk("starve_ram_we", int'(bus.o_ram_we), 1);
        chk("starve_ram_addr", int'(bus.o_ram_addr), 'h1000);
        chk("starve_ram_wdata", int'(bus.o_ram_wdata), 'hA5);
      end
      next_cycle();
      if (k == 8) bus.i_cpu_req = 1'b0;
    end
    clear_reqs();
    idle(2);

    // Video reads back the starved write.
    bus.i_vid_req = 1'b1; bus.i_vid_addr = 13'h1000;
    next_cycle();
    clear_reqs();
    next_cycle();
    @(negedge clk);
    chk("vid_rb_rvalid", int'(bus.o_vid_rvalid), 1);
    chk("vid_rb_rdata", int'(bus.o_rdata), 'hA5);
    idle(3);

    // Single CPU read latency.
    bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 13'h0400;
    @(negedge clk);
    chk("lat_ack", int'(bus.o_cpu_ack), 1);
    next_cycle();
    clear_reqs();
    @(negedge clk);
    chk("lat_ram_en", int'(bus.o_ram_en), 1);
    chk("lat_ram_addr", int'(bus.o_ram_addr), 'h0400);
    chk("lat_rvalid_c1", int'(bus.o_cpu_rvalid), 0);
    next_cycle();
    @(negedge clk);
    chk("lat_rvalid_c2", int'(bus.o_cpu_rvalid), 1);
    chk("lat_rdata", int'(bus.o_rdata), 'h5A);
    next_cycle();
    @(negedge clk);
    chk("lat_rvalid_c3", int'(bus.o_cpu_rvalid), 0);
    idle(3);

    // DMA read killed by a reset on the following edge.
    bus.i_dma_req = 1'b1; bus.i_dma_we = 1'b0; bus.i_dma_addr = 13'h0400;
    @(negedge clk);
    chk("mid_dma_ack", int'(bus.o_dma_ack), 1);
    next_cycle();
    clear_reqs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_ram_en", int'(bus.o_ram_en), 0);
    chk("mid_dma_rvalid", int'(bus.o_dma_rvalid), 0);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video RAM arbiter for the Space Invaders SoC. It shares the 7 KB framebuffer between three requesters: the VGA scanout line fetcher, the 8080 CPU bus, and the sprite/clear DMA engine. It issues at most one RAM access per cycle. Video has fixed top priority, and CPU/DMA are served round-robin with a starvation override. It sits in the `i_clk` (CPU/system) domain between the requesters and the VRAM block.

## Interface
- `AW`, 13, RAM address width
- `DW`, 8, RAM data width
- `STARVE`, 8, cycles a CPU/DMA request may wait before it overrides video (1..255)

Ports:
- `i_clk`  in  1  system clock; all logic is on its rising edge
- `i_rst`  in  1  synchronous, active-high reset
- `i_vid_req`  in  1  video read request, held until acked
- `i_vid_addr`  in  AW  video read address
- `o_vid_ack`  out  1  video request accepted this cycle
- `o_vid_rvalid`  out  1  `o_rdata` holds video read data
- `i_cpu_req`, `i_cpu_we`  in  1 each  CPU request and write enable
- `i_cpu_addr`  in  AW  CPU address
- `i_cpu_wdata`  in  DW  CPU write data
- `o_cpu_ack`, `o_cpu_rvalid`  out  1 each  CPU accept and read-data valid
- `i_dma_req`, `i_dma_we`  in  1 each  DMA request and write enable
- `i_dma_addr`  in  AW  DMA address
- `i_dma_wdata`  in  DW  DMA write data
- `o_dma_ack`, `o_dma_rvalid`  out  1 each  DMA accept and read-data valid
- `o_rdata`  out  DW  shared read data, qualified by the `*_rvalid` strobes
- `o_ram_en`, `o_ram_we`  out  1 each  registered RAM enable and write strobe
- `o_ram_addr`  out  AW  registered RAM address
- `o_ram_wdata`  out  DW  registered RAM write data
- `i_ram_rdata`  in  DW  RAM read data, synchronous with 1-cycle latency

## Operation
- **Handshake:** valid/ready style.
  - A transfer is accepted at the edge where `req` and `ack` are both high.
  - Each `ack` is combinational from the `req` inputs and internal registers. Requesters must not derive `req` from `ack`.
  - A requester keeps `req`, `addr`, `we` and `wdata` stable until it is acked. Back-to-back accepts on the same port are legal.
- **Grant order each cycle:**
  1. A starved port, i.e. CPU or DMA with wait counter == `STARVE`.
  2. Video.
  3. CPU or DMA by round-robin.
  - If CPU and DMA are both starved, or both are requesting without starvation, the round-robin pointer decides.
  - Exactly one `ack` is high, or none.
- **Round-robin pointer:** 1 bit, holding the last served of CPU or DMA. It flips toward the other port whenever CPU or DMA is acked. The port not last served wins ties.
- **Wait counters:** one per CPU and DMA, 8 bits.
  - Increment, saturating at `STARVE`, in each cycle where `req` is high and `ack` is low.
  - Clear on ack.
  - Hold at 0 while `req` is low.
- **Issue:** on the accept edge, `o_ram_en` is set to 1 and the winner's `we`, `addr` and `wdata` are loaded into the `o_ram_*` registers. If nothing is accepted, `o_ram_en` and `o_ram_we` go to 0. Address and wdata then hold their previous values.
- **Read return:** a 2-bit tag (none/vid/cpu/dma) is registered with the issue, for reads only.
  - The tag is delayed one more cycle. The matching `*_rvalid` is then high for exactly one cycle.
  - `o_rdata` equals `i_ram_rdata`, passed through combinationally.
  - Writes produce no `rvalid`.
- **Reset:**
  - All acks are forced to 0 while `i_rst` is high.
  - `o_ram_en`, `o_ram_we`, `o_ram_addr`, `o_ram_wdata` and all `rvalid`s reset to 0.
  - Counters reset to 0. The round-robin pointer resets to "DMA last", so the CPU wins the first tie.
  - A read issued in the cycle before reset asserts produces no `rvalid`: the tag pipeline is cleared.

## Timing
- The accept happens at edge E.
- The RAM command is visible on `o_ram_*` during cycle E..E+1, and the RAM samples it at E+1.
- `*_rvalid` and valid `o_rdata` appear during cycle E+1..E+2. Read latency is 2 edges from accept.
- Throughput is 1 access per cycle in aggregate and on any single port.
- With a continuous video request, a CPU request is acked no later than `STARVE` + 1 cycles after it rises.
- Simultaneous starvation of CPU and DMA resolves by round-robin in the same cycle. The other port is served in the next cycle, ahead of video, because its counter is still at `STARVE`.

## Test plan
- **Reset:**
  - Stimulus: hold `i_rst` for 3 cycles with all `req`s high.
  - Required: all acks and `rvalid`s are 0, `o_ram_en` is 0, and the first post-reset accept goes to video.
- **Read latency:**
  - Stimulus: a single CPU read of 0x0400 with RAM preloaded to 0x5A.
  - Required: `o_cpu_ack` in cycle 0; `o_ram_addr`=0x0400 with `o_ram_en`=1 in cycle 1; `o_cpu_rvalid`=1 with `o_rdata`=0x5A in cycle 2 only.
- **Round-robin:**
  - Stimulus: CPU and DMA request continuously, no video.
  - Required: acks alternate CPU, DMA, CPU, DMA…, starting with CPU, and `o_ram_en`=1 every cycle.
- **Starvation:**
  - Stimulus: video requests continuously, CPU write of 0xA5 to 0x1000 with `STARVE`=8.
  - Required: `o_vid_ack` for 8 cycles, then `o_cpu_ack` on the 9th cycle, with `o_ram_we`=1, addr 0x1000 and wdata 0xA5 one cycle later.
- **Double starvation:**
  - Stimulus: video continuous; CPU and DMA both rise in the same cycle.
  - Required: once both counters reach 8, they are served CPU then DMA in consecutive cycles, then video resumes.
- **Reset mid-read:**
  - Stimulus: DMA read accepted, then `i_rst` asserted on the next edge.
  - Required: `o_dma_rvalid` stays 0, and `o_ram_en` is 0 the cycle after reset.
